// File: rtl/ahb_sram_port_arbiter_if.sv
// Signal bundle for ahb_sram_port_arbiter: bridge (A) side, port-B valid/ready side and SRAM macro pins.
// slave = the arbiter; master = the requesters and the macro.
interface ahb_sram_port_arbiter_if #(
  parameter int AW    = 14,
  parameter int CNT_W = 16
);
  logic            a_cs;
  logic [3:0]      a_wen;
  logic [AW-3:0]   a_addr;
  logic [31:0]     a_wdata;
  logic            b_req;
  logic            b_we;
  logic [3:0]      b_be;
  logic [AW-3:0]   b_addr;
  logic [31:0]     b_wdata;
  logic            b_gnt;
  logic            b_rvalid;
  logic [31:0]     b_rdata;
  logic            b_starve;
  logic            b_starve_clr;
  logic [CNT_W-1:0] b_gnt_cnt;
  logic            ahb_stall;
  logic            SRAMCS;
  logic [3:0]      SRAMWEN;
  logic [AW-3:0]   SRAMADDR;
  logic [31:0]     SRAMWDATA;
  logic [31:0]     SRAMRDATA;

  modport slave (
    input  a_cs, a_wen, a_addr, a_wdata,
    input  b_req, b_we, b_be, b_addr, b_wdata, b_starve_clr, SRAMRDATA,
    output b_gnt, b_rvalid, b_rdata, b_starve, b_gnt_cnt, ahb_stall,
    output SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA
  );

  modport master (
    output a_cs, a_wen, a_addr, a_wdata,
    output b_req, b_we, b_be, b_addr, b_wdata, b_starve_clr, SRAMRDATA,
    input  b_gnt, b_rvalid, b_rdata, b_starve, b_gnt_cnt, ahb_stall,
    input  SRAMCS, SRAMWEN, SRAMADDR, SRAMWDATA
  );
endinterface

// File: rtl/ahb_sram_port_arbiter.sv
// Shares one SRAM between the AHB bridge (A, absolute priority) and port B; grant/mux same cycle, B read data +1 cycle.
// B waits while a_cs is high; SRAM_ARB_STALL_EN adds a registered ahb_stall once B starves.
module ahb_sram_port_arbiter #(
  parameter int AW           = 14,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_sram_port_arbiter_if.slave bus
);

`ifdef SRAM_ARB_STALL_EN
  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             starve_set;
  logic             starve_q;
  logic             rd_pend;
  logic [31:0]      rdata_hold;
  logic [CNT_W-1:0] gnt_cnt;
  logic             gnt;

  assign gnt = bus.b_req & ~bus.a_cs;

  // Port A owns the macro whenever it selects it; address/data idle on A values.
  assign bus.b_gnt     = gnt;
  assign bus.SRAMCS    = bus.a_cs | gnt;
  assign bus.SRAMWEN   = bus.a_cs ? bus.a_wen : ((gnt & bus.b_we) ? bus.b_be : 4'h0);
  assign bus.SRAMADDR  = gnt ? bus.b_addr  : bus.a_addr;
  assign bus.SRAMWDATA = gnt ? bus.b_wdata : bus.a_wdata;

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    starve_set = 1'b0;
    if (!bus.b_req || gnt) begin
      state_nxt = IDLE;
      wait_nxt  = '0;
    end else begin
      unique case (state)
        IDLE, WAIT: begin
          // wait_cnt saturates at LIMIT so the flag is raised once per episode
          if (wait_cnt < LIMIT) begin
            wait_nxt  = wait_cnt + 8'd1;
            state_nxt = WAIT;
            if (wait_cnt + 8'd1 == LIMIT) begin
              starve_set = 1'b1;
`ifdef SRAM_ARB_STALL_EN
              state_nxt  = STALL;
`endif
            end
          end
        end
`ifdef SRAM_ARB_STALL_EN
        STALL:   state_nxt = STALL;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_q   <= 1'b0;
      rd_pend    <= 1'b0;
      rdata_hold <= '0;
      gnt_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (starve_set)
        starve_q <= 1'b1;
      else if (bus.b_starve_clr)
        starve_q <= 1'b0;
      rd_pend <= gnt & ~bus.b_we;
      if (rd_pend)
        rdata_hold <= bus.SRAMRDATA;
      if (gnt && (gnt_cnt != '1))
        gnt_cnt <= gnt_cnt + CNT_W'(1);
    end
  end

`ifdef SRAM_ARB_STALL_EN
  logic stall_q;

  // Registered from next state only, so a_cs never reaches HREADYOUT combinationally.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      stall_q <= 1'b0;
    else
      stall_q <= (state_nxt == STALL);
  end

  assign bus.ahb_stall = stall_q;
`else
  assign bus.ahb_stall = 1'b0;
`endif

  assign bus.b_rvalid  = rd_pend;
  assign bus.b_rdata   = rd_pend ? bus.SRAMRDATA : rdata_hold;
  assign bus.b_starve  = starve_q;
  assign bus.b_gnt_cnt = gnt_cnt;

endmodule

// File: doc/ahb_sram_port_arbiter.md
Name: ahb_sram_port_arbiter

Overview:
Shares one single-port 32-bit SRAM macro between the AHB-to-SRAM bridge (port A) and a secondary requester (port B: DMA, debug loader) using a valid/ready handshake. Sits between the bridge's SRAM-side outputs and the macro. Port A has absolute priority because the bridge cannot stall. Port B is served in idle SRAM cycles, with starvation detection and an optional AHB stall.

Parameters:
AW, 14, byte address width; SRAM word address is AW-2 bits
STARVE_LIMIT, 16, port-B wait cycles before starvation is declared (1..255)
CNT_W, 16, width of the saturating grant counter

Ports:
HCLK  in  1  system clock
HRESETn  in  1  async active-low reset
a_cs  in  1  bridge SRAM chip select
a_wen  in  4  bridge byte write enables
a_addr  in  AW-2  bridge word address
a_wdata  in  32  bridge write data
b_req  in  1  port-B request valid
b_we  in  1  port-B write (1) / read (0)
b_be  in  4  port-B byte enables (writes only)
b_addr  in  AW-2  port-B word address
b_wdata  in  32  port-B write data
b_gnt  out  1  port-B request accepted this cycle
b_rvalid  out  1  port-B read data valid
b_rdata  out  32  port-B read data
b_starve  out  1  sticky starvation flag
b_starve_clr  in  1  clears b_starve
b_gnt_cnt  out  CNT_W  saturating count of port-B grants
ahb_stall  out  1  registered; ANDed low into the system HREADYOUT mux
SRAMCS  out  1  macro chip select
SRAMWEN  out  4  macro byte write enables
SRAMADDR  out  AW-2  macro word address
SRAMWDATA  out  32  macro write data
SRAMRDATA  in  32  macro read data, one cycle after CS

Behaviour:
- Clock and reset: HCLK; HRESETn asynchronous, active-low. Reset clears all state. b_gnt, b_rvalid, b_starve, ahb_stall all 0; b_rdata 0; b_gnt_cnt 0; FSM in IDLE. A reset mid-transaction drops any pending B read with no b_rvalid.
- SRAM mux (combinational):
  - a_cs=1: macro driven from port A.
  - Else if b_gnt: driven from port B; SRAMWEN = b_we ? b_be : 0.
  - Else: SRAMCS=0, SRAMWEN=0, address and data hold the port-A values.
- Grant: b_gnt = b_req & ~a_cs (combinational, same cycle). Port B holds req/we/be/addr/wdata stable until b_gnt. Dropping b_req before grant returns the FSM to IDLE and clears the wait counter.
- Read return: granted B read sets rd_pend. Next cycle, b_rvalid=1 and b_rdata=SRAMRDATA. SRAMRDATA is also captured into a holding register, so b_rdata stays stable until the next B read's data. Port-A read data is never routed to b_rdata. Back-to-back B reads give b_rvalid on consecutive cycles.
- FSM states:
  - IDLE: on b_req & ~b_gnt, go to WAIT with wait_cnt=1. On b_req & b_gnt, stay in IDLE.
  - WAIT: wait_cnt increments per ungranted cycle. On b_gnt, go to IDLE and clear wait_cnt. When wait_cnt reaches STARVE_LIMIT, set b_starve and go to STALL (with macro) or stay in WAIT (without).
  - STALL: ahb_stall=1 (registered). On b_gnt, go to IDLE; ahb_stall falls the following cycle.
- Starvation flag: b_starve is sticky. If b_starve_clr and a set happen in the same cycle, set wins.
- Grant counter: b_gnt_cnt increments on each b_gnt and saturates at all-ones.
- No combinational path from a_cs to ahb_stall.

Optional Feature:
SRAM_ARB_STALL_EN
- Defined: STALL state is active. ahb_stall holds system HREADY low, which blocks new bridge accesses. The bridge may still drain one buffered write (a_cs=1), so B is granted within at most 2 stall cycles.
- Undefined: ahb_stall tied 0, STALL state absent, and WAIT persists after starvation. b_starve is still flagged.

Test Plan:
- Idle A, B read addr 0x010 with SRAMRDATA=0xCAFEF00D -> b_gnt in the same cycle, SRAMADDR=0x010; next cycle b_rvalid=1, b_rdata=0xCAFEF00D, held afterwards.
- a_cs=1 continuously for 5 cycles with B write pending -> b_gnt=0 throughout, macro driven by A; grant in the first cycle a_cs=0, SRAMWEN=b_be=4'b0011.
- STARVE_LIMIT=4, a_cs held 1 -> b_starve rises on the 4th wait cycle. With the macro, ahb_stall=1 the next cycle; releasing a_cs gives b_gnt, and ahb_stall falls 1 cycle later.
- Starvation set and b_starve_clr in the same cycle -> b_starve=1. A later clr alone -> b_starve=0.
- CNT_W=4, 17 B grants -> b_gnt_cnt saturates at 0xF.
- Reset asserted the cycle after a granted B read -> no b_rvalid, all outputs 0, FSM in IDLE.
